// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 round count, IV, FSM states and the FIPS 180-4 round/schedule functions
package sha256_pkg;
  localparam int ROUNDS = 64;
  localparam int K_LAT = 1;
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  typedef enum logic [1:0] {IDLE, PREFETCH, ROUND, FINAL} state_e;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word message window (load block_i, shift_i one word per round, w_o = W_t)
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [511:0] block_i,
  output logic [31:0]  w_o
);
  logic [0:15][31:0] w_q;
  always_ff @(posedge clk) begin
    if (rst) w_q <= '0;
    else if (load_i) w_q <= block_i;
    else if (shift_i) w_q <= {w_q[1:15], ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0]};
  end
  assign w_o = w_q[0];
endmodule

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: one-block SHA-256 compression (start/block_in/chain_in in, k_select/k_data ROM port, busy/done/digest out)
module sha256_round_engine
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] chain_in,
  output logic [5:0]   k_select,
  input  logic [31:0]  k_data,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);
  state_e state_q, state_d;
  logic [5:0] t_q;
  logic [7:0][31:0] v_q, h_q, digest_q;
  logic done_q;
  logic [31:0] w_t, t1, t2;
  sha256_msg_sched u_sched (
    .clk(clk),
    .rst(rst),
    .load_i(state_q == IDLE && start),
    .shift_i(state_q == ROUND),
    .block_i(block_in),
    .w_o(w_t)
  );
  always_comb begin
    t1 = v_q[0] + bsig1(v_q[3]) + ch(v_q[3], v_q[2], v_q[1]) + k_data + w_t;
    t2 = bsig0(v_q[7]) + maj(v_q[7], v_q[6], v_q[5]);
    state_d = state_q == IDLE     ? (start ? PREFETCH : IDLE) :
              state_q == PREFETCH ? ROUND :
              state_q == ROUND    ? (t_q == 6'(ROUNDS - 1) ? FINAL : ROUND) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      t_q      <= '0;
      v_q      <= '0;
      h_q      <= '0;
      digest_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= state_q == FINAL;
      if (state_q == IDLE && start) begin
        v_q <= chain_in;
        h_q <= chain_in;
      end
      if (state_q == PREFETCH) t_q <= '0;
      if (state_q == ROUND) begin
        t_q <= t_q + 6'd1;
        v_q <= {t1 + t2, v_q[7:5], v_q[4] + t1, v_q[3:1]};
      end
      if (state_q == FINAL)
        for (int i = 0; i < 8; i++) digest_q[i] <= h_q[i] + v_q[i];
    end
  end
  assign k_select = state_q == ROUND ? t_q + 6'd1 : 6'd0;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign digest = digest_q;
endmodule

// File: tb/tb_sha256_round_engine.sv
// tb_sha256_round_engine: randomized scoreboard bench against a loop-based SHA-256 reference with a 1-clock K ROM
module tb_sha256_round_engine;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, busy, done;
  logic [511:0] block_in = '0;
  logic [255:0] chain_in = '0, digest;
  logic [5:0] k_select;
  logic [31:0] k_data = '0;
  int n_vec = 0, n_err = 0;
  logic [255:0] sb[$];
  logic [255:0] last_exp;
  localparam logic [255:0] H_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  sha256_round_engine dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .block_in(block_in),
    .chain_in(chain_in),
    .k_select(k_select),
    .k_data(k_data),
    .busy(busy),
    .done(done),
    .digest(digest)
  );
  always #5 clk = ~clk;
  always @(posedge clk) k_data <= k_tab[k_select];
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction
  function automatic logic [255:0] sha_ref(input logic [511:0] blk, input logic [255:0] chn);
    logic [31:0] w[64];
    logic [31:0] v[8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = chn[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tab[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = chn[255 - 32*i -: 32] + v[i];
    return r;
  endfunction
  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL spurious_done digest=%h exp=none", digest);
      end else begin
        last_exp = sb.pop_front();
        if (digest !== last_exp) begin
          n_err++;
          $display("FAIL digest got=%h exp=%h", digest, last_exp);
        end
      end
    end
  end
  task automatic run_job(input logic [511:0] blk, input logic [255:0] chn, input logic [255:0] exp,
                         input int mode, input int at, input bit imm, input bit trace);
    int cnt;
    bit k_ok, b_ok;
    if (!imm) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    block_in = blk;
    chain_in = chn;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt = 0;
    k_ok = 1'b1;
    b_ok = 1'b1;
    while (!done && cnt < 200) begin
      if (trace && k_select !== ((cnt >= 1 && cnt <= 63) ? 6'(cnt) : 6'd0)) k_ok = 1'b0;
      if (!busy) b_ok = 1'b0;
      start = mode == 1 && cnt == at;
      if (start) begin
        block_in = rnd512();
        chain_in = {rnd512(), rnd512()} >> 768;
      end
      if (mode == 2 && cnt == at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_back());
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_digest", digest, 256'd0);
        chk("rst_k_select", 256'(k_select), 256'd0);
        return;
      end
      @(posedge clk);
      #1;
      cnt++;
    end
    start = 1'b0;
    chk("latency", 256'(cnt), 256'd66);
    chk("busy_window", 256'({b_ok, busy}), 256'b10);
    if (trace) chk("k_select_trace", 256'(k_ok), 256'd1);
  endtask
  initial begin
    logic [511:0] abc, empty, b1, b2, r;
    logic [255:0] c, h1;
    logic [447:0] msg;
    abc = {24'h616263, 8'h80, 416'h0, 64'h18};
    empty = {8'h80, 504'h0};
    msg = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    b1 = {msg, 8'h80, 56'h0};
    b2 = {448'h0, 64'd448};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", 256'(busy), 256'd0);
    chk("reset_done", 256'(done), 256'd0);
    chk("reset_digest", digest, 256'd0);
    chk("reset_k_select", 256'(k_select), 256'd0);
    run_job(abc, H_IV, 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad, 0, 0, 0, 1);
    run_job(empty, H_IV, 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855, 0, 0, 0, 0);
    h1 = sha_ref(b1, H_IV);
    run_job(b1, H_IV, h1, 0, 0, 0, 0);
    run_job(b2, h1, 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1, 0, 0, 1, 0);
    r = rnd512();
    run_job(r, H_IV, sha_ref(r, H_IV), 1, 11, 0, 0);
    r = rnd512();
    run_job(r, H_IV, sha_ref(r, H_IV), 2, 31, 0, 0);
    run_job(abc, H_IV, 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      r = rnd512();
      c = {rnd512(), rnd512()} >> 768;
      run_job(r, c, sha_ref(r, c), 0, 0, i[0], 0);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("digest_held", digest, last_exp);
    chk("scoreboard_drained", 256'(sb.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
